operand_regfile: RTL and testbench

OPERAND_REGFILE -- requirements
Module: operand_regfile

---
 rtl/operand_regfile.sv | 107 ++++++++++
 tb/tb_operand_regfile.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_regfile.sv
// operand_regfile: eight-entry register file feeding a registered operand
// stage (OpA/OpB/FS) through a valid/ready handshake, plus a status-flag
// register. Writes use a write-first bypass into the operand capture.
// Optional build macro: R0_ZERO_EN -- when defined, R0 is hardwired to zero
// (writes to address 0 are dropped and never bypassed).
module operand_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RW,
    input  logic [2:0]        DA,
    input  logic [DATA_W-1:0] D,
    input  logic [2:0]        AA,
    input  logic [2:0]        BA,
    input  logic              MB,
    input  logic [DATA_W-1:0] KNS,
    input  logic [3:0]        FS_in,
    input  logic              issue,
    output logic              issue_ready,
    input  logic              fu_ready,
    output logic [DATA_W-1:0] OpA,
    output logic [DATA_W-1:0] OpB,
    output logic [3:0]        FS,
    output logic              op_valid,
    input  logic              SL,
    input  logic              V_in,
    input  logic              C_in,
    input  logic              N_in,
    input  logic              Z_in,
    output logic [3:0]        status
);

    logic [DATA_W-1:0] r_regs [8];
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [3:0]        r_fs;
    logic              r_op_valid;
    logic [3:0]        r_status;

    logic              w_we;
    logic              w_capture;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // Effective write enable; address 0 is read-only when R0 is hardwired.
`ifdef R0_ZERO_EN
    assign w_we = RW && (DA != 3'd0);
`else
    assign w_we = RW;
`endif

    // A new operand set is accepted when the stage is empty or being drained.
    assign issue_ready = !r_op_valid || fu_ready;
    assign w_capture   = issue && issue_ready;

    // Operand read with write-first bypass; KNS replaces source B when MB=1.
    assign w_rd_a = (w_we && (DA == AA)) ? D : r_regs[AA];
    assign w_rd_b = MB ? KNS :
                    (w_we && (DA == BA)) ? D : r_regs[BA];

    // Register file write port, independent of the operand handshake.
    // NOTE: the array is reset explicitly because software relies on every
    // register reading zero after reset; this rules out a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[DA] <= D;
        end
    end

    // Operand stage: capture on accept, drop valid on consume, hold on stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_fs       <= '0;
            r_op_valid <= 1'b0;
        end else if (w_capture) begin
            r_op_a     <= w_rd_a;
            r_op_b     <= w_rd_b;
            r_fs       <= FS_in;
            r_op_valid <= 1'b1;
        end else if (r_op_valid && fu_ready) begin
            r_op_valid <= 1'b0;
        end
    end

    // Status flags {V,C,N,Z}, loaded only when SL is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= '0;
        end else if (SL) begin
            r_status <= {V_in, C_in, N_in, Z_in};
        end
    end

    assign OpA      = r_op_a;
    assign OpB      = r_op_b;
    assign FS       = r_fs;
    assign op_valid = r_op_valid;
    assign status   = r_status;

endmodule

// File: tb/tb_operand_regfile.sv
// Directed testbench for operand_regfile. Inputs change and outputs are
// sampled 1 ns after each rising edge; expected values are hand-computed.
module tb_operand_regfile;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              RW = 1'b0;
    logic [2:0]        DA = '0;
    logic [DATA_W-1:0] D = '0;
    logic [2:0]        AA = '0;
    logic [2:0]        BA = '0;
    logic              MB = 1'b0;
    logic [DATA_W-1:0] KNS = '0;
    logic [3:0]        FS_in = '0;
    logic              issue = 1'b0;
    logic              issue_ready;
    logic              fu_ready = 1'b0;
    logic [DATA_W-1:0] OpA;
    logic [DATA_W-1:0] OpB;
    logic [3:0]        FS;
    logic              op_valid;
    logic              SL = 1'b0;
    logic              V_in = 1'b0;
    logic              C_in = 1'b0;
    logic              N_in = 1'b0;
    logic              Z_in = 1'b0;
    logic [3:0]        status;

    int checks = 0;
    int errors = 0;

`ifdef R0_ZERO_EN
    localparam logic [DATA_W-1:0] R0_WRITE_EXP  = 16'h0000;
    localparam logic [DATA_W-1:0] R0_BYPASS_EXP = 16'h0000;
`else
    localparam logic [DATA_W-1:0] R0_WRITE_EXP  = 16'hFFFF;
    localparam logic [DATA_W-1:0] R0_BYPASS_EXP = 16'h1111;
`endif

    operand_regfile #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .RW         (RW),
        .DA         (DA),
        .D          (D),
        .AA         (AA),
        .BA         (BA),
        .MB         (MB),
        .KNS        (KNS),
        .FS_in      (FS_in),
        .issue      (issue),
        .issue_ready(issue_ready),
        .fu_ready   (fu_ready),
        .OpA        (OpA),
        .OpB        (OpB),
        .FS         (FS),
        .op_valid   (op_valid),
        .SL         (SL),
        .V_in       (V_in),
        .C_in       (C_in),
        .N_in       (N_in),
        .Z_in       (Z_in),
        .status     (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and idle state
        #1 reset = 1'b1;
        tick();
        check("rst_op_valid", 32'(op_valid), 32'h0);
        check("rst_opa", 32'(OpA), 32'h0);
        check("rst_opb", 32'(OpB), 32'h0);
        check("rst_fs", 32'(FS), 32'h0);
        check("rst_status", 32'(status), 32'h0);
        check("rst_issue_ready", 32'(issue_ready), 32'h1);
        reset = 1'b0;
        fu_ready = 1'b1;

        // Basic writes then capture
        RW = 1'b1; DA = 3'd3; D = 16'h1234;
        tick();
        DA = 3'd5; D = 16'h00FF;
        tick();
        RW = 1'b0;
        issue = 1'b1; AA = 3'd3; BA = 3'd5; MB = 1'b0; FS_in = 4'b1000;
        tick();
        check("cap_opa", 32'(OpA), 32'h1234);
        check("cap_opb", 32'(OpB), 32'h00FF);
        check("cap_fs", 32'(FS), 32'h8);
        check("cap_valid", 32'(op_valid), 32'h1);

        // Write-first bypass on both sources, back-to-back issue
        RW = 1'b1; DA = 3'd2; D = 16'hBEEF;
        AA = 3'd2; BA = 3'd2; FS_in = 4'b0001;
        tick();
        check("byp_opa", 32'(OpA), 32'hBEEF);
        check("byp_opb", 32'(OpB), 32'hBEEF);
        check("b2b_valid", 32'(op_valid), 32'h1);
        RW = 1'b0; MB = 1'b1; KNS = 16'h0007;
        tick();
        check("kns_opa", 32'(OpA), 32'hBEEF);
        check("kns_opb", 32'(OpB), 32'h0007);

        // Consume without new issue: valid clears, operands kept
        issue = 1'b0; MB = 1'b0;
        tick();
        check("drain_valid", 32'(op_valid), 32'h0);
        check("drain_opa", 32'(OpA), 32'hBEEF);
        check("drain_opb", 32'(OpB), 32'h0007);
        check("drain_fs", 32'(FS), 32'h1);
        check("drain_ready", 32'(issue_ready), 32'h1);

        // Stall: held set, ignored issue, register write proceeds
        issue = 1'b1; AA = 3'd3; BA = 3'd5; FS_in = 4'd2;
        tick();
        check("pre_stall_opa", 32'(OpA), 32'h1234);
        fu_ready = 1'b0;
        AA = 3'd5; BA = 3'd3; FS_in = 4'd3;
        RW = 1'b1; DA = 3'd5; D = 16'hAAAA;
        #1;
        check("stall_ready", 32'(issue_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            RW = 1'b0;
            check("stall_opa", 32'(OpA), 32'h1234);
            check("stall_opb", 32'(OpB), 32'h00FF);
            check("stall_fs", 32'(FS), 32'h2);
            check("stall_valid", 32'(op_valid), 32'h1);
            check("stall_ready_n", 32'(issue_ready), 32'h0);
        end
        fu_ready = 1'b1;
        #1;
        check("unstall_ready", 32'(issue_ready), 32'h1);
        tick();
        check("unstall_opa", 32'(OpA), 32'hAAAA);
        check("unstall_opb", 32'(OpB), 32'h1234);
        check("unstall_fs", 32'(FS), 32'h3);
        issue = 1'b0;

        // Status load and hold
        SL = 1'b1; V_in = 1'b1; C_in = 1'b0; N_in = 1'b1; Z_in = 1'b0;
        tick();
        check("status_load", 32'(status), 32'hA);
        SL = 1'b0; V_in = 1'b0; C_in = 1'b1; N_in = 1'b0; Z_in = 1'b1;
        tick();
        check("status_hold", 32'(status), 32'hA);

        // Asynchronous reset mid-stall
        fu_ready = 1'b0; issue = 1'b1; AA = 3'd3; BA = 3'd5;
        tick();
        check("pre_rst_valid", 32'(op_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(op_valid), 32'h0);
        check("arst_status", 32'(status), 32'h0);
        check("arst_opa", 32'(OpA), 32'h0);
        check("arst_opb", 32'(OpB), 32'h0);
        check("arst_ready", 32'(issue_ready), 32'h1);
        // No capture or write while reset is held across an edge
        fu_ready = 1'b1; RW = 1'b1; DA = 3'd3; D = 16'h5555;
        tick();
        check("inrst_valid", 32'(op_valid), 32'h0);
        check("inrst_opa", 32'(OpA), 32'h0);
        reset = 1'b0; RW = 1'b0; issue = 1'b1; AA = 3'd3; BA = 3'd5; MB = 1'b0;
        tick();
        check("post_rst_r3", 32'(OpA), 32'h0);
        check("post_rst_r5", 32'(OpB), 32'h0);
        issue = 1'b0;

        // R0 behaviour (hardwired zero only with R0_ZERO_EN)
        RW = 1'b1; DA = 3'd0; D = 16'hFFFF;
        tick();
        RW = 1'b0; issue = 1'b1; AA = 3'd0; BA = 3'd0;
        tick();
        check("r0_write_opa", 32'(OpA), 32'(R0_WRITE_EXP));
        check("r0_write_opb", 32'(OpB), 32'(R0_WRITE_EXP));
        RW = 1'b1; DA = 3'd0; D = 16'h1111;
        tick();
        check("r0_bypass_opa", 32'(OpA), 32'(R0_BYPASS_EXP));
        RW = 1'b0; issue = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
